// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic sequencer: opcode encodings, FSM state
// type and default widths.
package arith_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NREGS_DEF  = 4;

    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Encodings above OP_SUB have no engine function and are reported as errors.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_SUB);
    endfunction

endpackage

// File: rtl/arith_regfile.sv
// Register file for the arithmetic sequencer: two asynchronous read ports,
// one synchronous write port, cleared by the asynchronous active-low reset.
module arith_regfile
    import arith_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREGS  = NREGS_DEF,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] addr_a,
    output logic [DATA_W-1:0] data_a,
    input  logic [REG_AW-1:0] addr_b,
    output logic [DATA_W-1:0] data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign data_a = regs[addr_a];
    assign data_b = regs[addr_b];

endmodule

// File: rtl/arithmetic_sequencer.sv
// Command sequencer driving an external arithmetic engine over a small register file.
// Optional Z/N status flags are built when ARITH_SEQ_FLAGS_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a command; captures it on valid&ready
// ST_EXEC | drives engine from captured operands; writes rd and result
// ST_RESP | presents result until the consumer takes it
module arithmetic_sequencer
    import arith_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREGS  = NREGS_DEF,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_load,
    input  logic [2:0]        i_cmd_op,
    input  logic [REG_AW-1:0] i_cmd_ra,
    input  logic [REG_AW-1:0] i_cmd_rb,
    input  logic [REG_AW-1:0] i_cmd_rd,
    input  logic [DATA_W-1:0] i_cmd_imm,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [2:0]        o_alu_instruction,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_res_valid,
    output logic [DATA_W-1:0] o_res_data,
    output logic              o_res_err,
`ifdef ARITH_SEQ_FLAGS_EN
    output logic              o_flag_z,
    output logic              o_flag_n,
`endif
    input  logic              i_res_ready
);

    state_t state, state_nxt;

    logic              load_q;
    logic [2:0]        op_q;
    logic [REG_AW-1:0] ra_q, rb_q, rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_err_q;

    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              accept;
    logic              in_exec;
    logic              op_err;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    // Ready is masked by reset so upstream never sees a handshake while held in reset.
    assign o_cmd_ready = (state == ST_IDLE) && i_rst_n;
    assign accept      = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (i_res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_exec           = (state == ST_EXEC);
        op_err            = !load_q && !op_is_legal(op_q);
        wr_data           = load_q ? imm_q : i_alu_result;
        wr_en             = in_exec && !op_err;
        o_alu_a           = '0;
        o_alu_b           = '0;
        o_alu_instruction = 3'b000;
        if (in_exec) begin
            o_alu_a           = rdata_a;
            o_alu_b           = rdata_b;
            o_alu_instruction = op_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            load_q <= 1'b0;
            op_q   <= 3'b000;
            ra_q   <= '0;
            rb_q   <= '0;
            rd_q   <= '0;
            imm_q  <= '0;
        end else if (accept) begin
            load_q <= i_cmd_load;
            op_q   <= i_cmd_op;
            ra_q   <= i_cmd_ra;
            rb_q   <= i_cmd_rb;
            rd_q   <= i_cmd_rd;
            imm_q  <= i_cmd_imm;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else if (in_exec) begin
            res_data_q <= op_err ? '0 : wr_data;
            res_err_q  <= op_err;
        end
    end

    assign o_res_valid = (state == ST_RESP);
    assign o_res_data  = res_data_q;
    assign o_res_err   = res_err_q;

`ifdef ARITH_SEQ_FLAGS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_flag_z <= 1'b0;
            o_flag_n <= 1'b0;
        end else if (wr_en) begin
            o_flag_z <= (wr_data == '0);
            o_flag_n <= wr_data[DATA_W-1];
        end
    end
`endif

    // Reads are combinational and the write lands at the end of EXEC, so aliased
    // source/destination operands always see the pre-write value.
    arith_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .addr_a  (ra_q),
        .data_a  (rdata_a),
        .addr_b  (rb_q),
        .data_b  (rdata_b),
        .wr_en   (wr_en),
        .wr_addr (rd_q),
        .wr_data (wr_data)
    );

endmodule

// File: tb/tb_arithmetic_sequencer.sv
// Directed testbench for arithmetic_sequencer with a behavioural engine model.
// Flag checks are included when ARITH_SEQ_FLAGS_EN is defined.
module tb_arithmetic_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_ra, cmd_rb, cmd_rd;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_instruction;
    logic [7:0] alu_result;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_err;
    logic       res_ready;
`ifdef ARITH_SEQ_FLAGS_EN
    logic       flag_z, flag_n;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arithmetic_sequencer #(.DATA_W(8), .NREGS(4)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_cmd_valid       (cmd_valid),
        .o_cmd_ready       (cmd_ready),
        .i_cmd_load        (cmd_load),
        .i_cmd_op          (cmd_op),
        .i_cmd_ra          (cmd_ra),
        .i_cmd_rb          (cmd_rb),
        .i_cmd_rd          (cmd_rd),
        .i_cmd_imm         (cmd_imm),
        .o_alu_a           (alu_a),
        .o_alu_b           (alu_b),
        .o_alu_instruction (alu_instruction),
        .i_alu_result      (alu_result),
        .o_res_valid       (res_valid),
        .o_res_data        (res_data),
        .o_res_err         (res_err),
`ifdef ARITH_SEQ_FLAGS_EN
        .o_flag_z          (flag_z),
        .o_flag_n          (flag_n),
`endif
        .i_res_ready       (res_ready)
    );

    // External engine; illegal opcodes return a non-zero pattern so a missing
    // error-zeroing path is visible on o_res_data.
    always_comb begin
        case (alu_instruction)
            3'b000:  alu_result = alu_a | alu_b;
            3'b001:  alu_result = ~(alu_a & alu_b);
            3'b010:  alu_result = ~(alu_a | alu_b);
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a + alu_b;
            3'b101:  alu_result = alu_a - alu_b;
            default: alu_result = 8'hA5;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full command: accept, EXEC (operands checked), optional backpressure
    // with a competing command offered, then the result handshake.
    task automatic run_cmd(input string tag, input logic ld, input logic [2:0] op,
                           input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                           input logic [7:0] imm, input logic [7:0] exp_a, input logic [7:0] exp_b,
                           input logic [7:0] exp_data, input logic exp_err, input int hold);
        @(negedge clk);
        check({tag, "/idle_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_imm   = imm;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "/exec_valid"}, 32'(res_valid), 32'd0);
        check({tag, "/exec_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "/exec_a"}, 32'(alu_a), 32'(exp_a));
        check({tag, "/exec_b"}, 32'(alu_b), 32'(exp_b));
        check({tag, "/exec_instr"}, 32'(alu_instruction), 32'(op));
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_load  = 1'b1;
            cmd_rd    = rd;
            cmd_imm   = 8'h99;
            check({tag, "/hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, "/hold_data"}, 32'(res_data), 32'(exp_data));
            check({tag, "/hold_ready"}, 32'(cmd_ready), 32'd0);
            check({tag, "/hold_alu_a"}, 32'(alu_a), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check({tag, "/resp_valid"}, 32'(res_valid), 32'd1);
        check({tag, "/resp_data"}, 32'(res_data), 32'(exp_data));
        check({tag, "/resp_err"}, 32'(res_err), 32'(exp_err));
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "/done_valid"}, 32'(res_valid), 32'd0);
        check({tag, "/done_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_ra    = 2'd0;
        cmd_rb    = 2'd0;
        cmd_rd    = 2'd0;
        cmd_imm   = 8'h00;
        res_ready = 1'b0;

        #1;
        check("rst/cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst/res_valid", 32'(res_valid), 32'd0);
        check("rst/res_data", 32'(res_data), 32'd0);
        check("rst/res_err", 32'(res_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel/cmd_ready", 32'(cmd_ready), 32'd1);
        check("rel/alu_a", 32'(alu_a), 32'd0);
        check("rel/alu_instr", 32'(alu_instruction), 32'd0);

        //      tag            ld    op      ra    rb    rd    imm    a      b      data   err  hold
        run_cmd("load_r0",     1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h05, 8'h00, 8'h00, 8'h05, 1'b0, 0);
        run_cmd("load_r1",     1'b1, 3'b000, 2'd0, 2'd0, 2'd1, 8'h03, 8'h05, 8'h05, 8'h03, 1'b0, 0);
        run_cmd("add_r2",      1'b0, 3'b100, 2'd0, 2'd1, 2'd2, 8'h00, 8'h05, 8'h03, 8'h08, 1'b0, 0);
        run_cmd("sub_wrap",    1'b0, 3'b101, 2'd1, 2'd0, 2'd3, 8'h00, 8'h03, 8'h05, 8'hFE, 1'b0, 0);
        run_cmd("and_r3",      1'b0, 3'b011, 2'd0, 2'd1, 2'd3, 8'h00, 8'h05, 8'h03, 8'h01, 1'b0, 0);
        run_cmd("nand_r3",     1'b0, 3'b001, 2'd0, 2'd1, 2'd3, 8'h00, 8'h05, 8'h03, 8'hFE, 1'b0, 0);
        run_cmd("nor_r3",      1'b0, 3'b010, 2'd0, 2'd1, 2'd3, 8'h00, 8'h05, 8'h03, 8'hF8, 1'b0, 0);
        run_cmd("or_r3",       1'b0, 3'b000, 2'd0, 2'd1, 2'd3, 8'h00, 8'h05, 8'h03, 8'h07, 1'b0, 0);
        run_cmd("op110",       1'b0, 3'b110, 2'd0, 2'd1, 2'd2, 8'h00, 8'h05, 8'h03, 8'h00, 1'b1, 0);
        run_cmd("rb_r2",       1'b0, 3'b000, 2'd2, 2'd2, 2'd2, 8'h00, 8'h08, 8'h08, 8'h08, 1'b0, 0);
        run_cmd("op111",       1'b0, 3'b111, 2'd0, 2'd0, 2'd1, 8'h00, 8'h05, 8'h05, 8'h00, 1'b1, 0);
        run_cmd("rb_r1",       1'b0, 3'b000, 2'd1, 2'd1, 2'd3, 8'h00, 8'h03, 8'h03, 8'h03, 1'b0, 0);
        run_cmd("alias_add",   1'b0, 3'b100, 2'd1, 2'd1, 2'd1, 8'h00, 8'h03, 8'h03, 8'h06, 1'b0, 0);
        run_cmd("rb_alias",    1'b0, 3'b000, 2'd1, 2'd1, 2'd3, 8'h00, 8'h06, 8'h06, 8'h06, 1'b0, 0);
        run_cmd("load_ff",     1'b1, 3'b000, 2'd0, 2'd0, 2'd3, 8'hFF, 8'h05, 8'h05, 8'hFF, 1'b0, 0);
        run_cmd("add_wrap_bp", 1'b0, 3'b100, 2'd3, 2'd0, 2'd3, 8'h00, 8'hFF, 8'h05, 8'h04, 1'b0, 5);
        run_cmd("rb_r3",       1'b0, 3'b000, 2'd3, 2'd3, 2'd2, 8'h00, 8'h04, 8'h04, 8'h04, 1'b0, 0);

        // Reset while an ADD to r2 sits in EXEC.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 3'b100;
        cmd_ra    = 2'd0;
        cmd_rb    = 2'd1;
        cmd_rd    = 2'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_exec/alu_a", 32'(alu_a), 32'h05);
        rst_n = 1'b0;
        #1;
        check("rst_exec/res_valid", 32'(res_valid), 32'd0);
        check("rst_exec/cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_exec/alu_a", 32'(alu_a), 32'd0);
        check("rst_exec/res_data", 32'(res_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_exec/res_valid2", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_exec/rel_ready", 32'(cmd_ready), 32'd1);

        run_cmd("rb_r2_rst",   1'b0, 3'b000, 2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0);
        run_cmd("rb_r0r1_rst", 1'b0, 3'b000, 2'd0, 2'd1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0);

`ifdef ARITH_SEQ_FLAGS_EN
        run_cmd("f_load_r0",   1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h05, 8'h00, 8'h00, 8'h05, 1'b0, 0);
        run_cmd("f_load_r1",   1'b1, 3'b000, 2'd0, 2'd0, 2'd1, 8'h03, 8'h05, 8'h05, 8'h03, 1'b0, 0);
        run_cmd("f_sub_zero",  1'b0, 3'b101, 2'd0, 2'd0, 2'd2, 8'h00, 8'h05, 8'h05, 8'h00, 1'b0, 0);
        check("flag_z_zero", 32'(flag_z), 32'd1);
        check("flag_n_zero", 32'(flag_n), 32'd0);
        run_cmd("f_sub_neg",   1'b0, 3'b101, 2'd1, 2'd0, 2'd2, 8'h00, 8'h03, 8'h05, 8'hFE, 1'b0, 0);
        check("flag_z_neg", 32'(flag_z), 32'd0);
        check("flag_n_neg", 32'(flag_n), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arithmetic_sequencer.md
ARITHMETIC_SEQUENCER -- requirements
Module: arithmetic_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width.
REQ-002 SHALL have parameter NREGS, default 4, register-file depth (power of 2); REG_AW = log2(NREGS).
REQ-003 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_cmd_valid  input  1  command offered.
REQ-006 SHALL have port o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
REQ-007 SHALL have port i_cmd_load  input  1  1 = load i_cmd_imm into rd, 0 = ALU operation.
REQ-008 SHALL have port i_cmd_op  input  3  ALU opcode: 000 OR, 001 NAND, 010 NOR, 011 AND, 100 ADD, 101 SUB.
REQ-009 SHALL have ports i_cmd_ra, i_cmd_rb, i_cmd_rd  input  REG_AW each  source A, source B, destination.
REQ-010 SHALL have port i_cmd_imm  input  DATA_W  immediate for loads.
REQ-011 SHALL have ports o_alu_a, o_alu_b  output  DATA_W, o_alu_instruction  output  3  drive the arithmetic engine.
REQ-012 SHALL have port i_alu_result  input  DATA_W  combinational engine result.
REQ-013 SHALL have ports o_res_valid  output  1, o_res_data  output  DATA_W, o_res_err  output  1, i_res_ready  input  1  result channel.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-015 IDLE: o_cmd_ready=1; on i_cmd_valid&o_cmd_ready SHALL register op, ra/rb/rd, imm, load flag and go to EXEC.
REQ-016 EXEC (one cycle): o_alu_a=reg[ra], o_alu_b=reg[rb], o_alu_instruction=op held stable; SHALL capture i_alu_result (or imm if load) into reg[rd] and o_res_data, go to RESP.
REQ-017 Opcodes 110/111 with load=0 SHALL NOT write reg[rd], SHALL set o_res_err=1, o_res_data=0.
REQ-018 RESP: o_res_valid=1, o_res_data/o_res_err stable until i_res_ready; then return to IDLE.
REQ-019 Latency accept-to-o_res_valid SHALL be exactly 2 cycles; max throughput 1 command per 3 cycles when i_res_ready held high.
REQ-020 o_cmd_ready SHALL be 0 in EXEC and RESP; commands held by upstream.
REQ-021 ra, rb, rd may alias; reads in EXEC SHALL use pre-write values.
REQ-022 ADD/SUB SHALL wrap modulo 2^DATA_W; no carry output.
REQ-023 Outside EXEC, o_alu_a/o_alu_b SHALL be 0 and o_alu_instruction 000.

Reset
REQ-024 i_rst_n low SHALL immediately force IDLE, all registers 0, o_res_valid=0, o_res_err=0, o_res_data=0, o_cmd_ready=0 while asserted, 1 on first cycle after release.
REQ-025 Reset mid-EXEC/RESP SHALL abort the command; no partial register write survives.

Configuration
REQ-026 Macro ARITH_SEQ_FLAGS_EN defined: ports o_flag_z, o_flag_n (output 1) SHALL be added, updated in EXEC on non-error commands (z = result==0, n = result MSB), reset 0, held otherwise.
REQ-027 Macro undefined: flag ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package arith_pkg SHALL hold opcode constants (OP_OR..OP_SUB), FSM state typedef, DATA_W default.
REQ-029 Register file SHALL be sub-module arith_regfile (2 async read ports, 1 sync write port, async active-low reset).
REQ-030 The engine SHALL be external; this block only drives its ports.

Verification
REQ-031 Load imm 0x05 -> r0, imm 0x03 -> r1: each response o_res_data 0x05 / 0x03, err 0.
REQ-032 ADD r2=r0+r1 -> 0x08; SUB r3=r1-r0 -> 0xFE (wrap); AND r0&r1 -> 0x01.
REQ-033 Opcode 110 -> o_res_err=1, o_res_data 0, destination register unchanged on readback.
REQ-034 Hold i_res_ready=0 for 5 cycles -> o_res_valid and data stable, o_cmd_ready=0 throughout.
REQ-035 Assert i_rst_n low in EXEC of ADD to r2 -> o_res_valid 0, later readback of r2 = 0x00.
REQ-036 With ARITH_SEQ_FLAGS_EN: SUB r0-r0 -> o_flag_z=1, o_flag_n=0; SUB r1-r0 where r1<r0 -> o_flag_n=1.
